usb_crc_serializer: RTL and testbench

- Parametrised successor of the token-only CRC5 encoder. It serialises a complete USB packet body: PID, then an LSB-first payload, then the inverted CRC.
- Supports three packet kinds: handshake (PID only), token (11 data bits + CRC5) and data (variable bit count + CRC16).
- Sits between the protocol FSM and the bit-stuffer/NRZI stage. It exposes a load handshake upstream and a per-bit valid/ready handshake downstream, so the stuffer can stall it.

---
 rtl/usb_crc_pkg.sv | 30 +++
 rtl/usb_crc_lfsr.sv | 33 +++
 rtl/usb_crc_serializer.sv | 194 +++++++++++++++++++
 tb/tb_usb_crc_serializer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared types and constants for the USB packet-body serializer and its CRC LFSRs.
package usb_crc_pkg;

   typedef enum logic [1:0] {
      PK_HSK   = 2'd0,
      PK_TOKEN = 2'd1,
      PK_DATA  = 2'd2,
      PK_RSVD  = 2'd3
   } pkt_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PID  = 2'd1,
      ST_DATA = 2'd2,
      ST_CRC  = 2'd3
   } ser_state_t;

   localparam logic [4:0]  CRC5_POLY      = 5'h05;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
   localparam int          TOKEN_BITS     = 11;
   localparam int          PID_BITS       = 8;

   // The reserved kind code is handled exactly like a handshake.
   function automatic logic is_hsk(input pkt_kind_t k);
      return (k == PK_HSK) || (k == PK_RSVD);
   endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial CRC register: accumulates payload bits, then shifts its contents out MSB first.
module usb_crc_lfsr #(
   parameter int            W    = 5,
   parameter logic [W-1:0]  POLY = W'(5)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init,
   input  logic         shift_en,
   input  logic         bit_in,
   input  logic         send_mode,
   output logic [W-1:0] crc
);

   logic fb;

   assign fb = crc[W-1] ^ bit_in;

   // Send mode refills with ones so the register is back at its seed once emptied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= '1;
      end else if (init) begin
         crc <= '1;
      end else if (shift_en) begin
         if (send_mode)
            crc <= {crc[W-2:0], 1'b1};
         else
            crc <= {crc[W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
   end

endmodule

// File: rtl/usb_crc_serializer.sv
// USB packet-body serializer: PID, LSB-first payload, inverted CRC5/CRC16, with per-bit valid/ready.
// Optional PID complement check enabled by defining USB_PID_CHECK_EN (adds pid_err output).
module usb_crc_serializer
   import usb_crc_pkg::*;
#(
   parameter int MAX_DATA_BITS = 64,
   parameter int LEN_W         = $clog2(MAX_DATA_BITS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  pkt_kind_t                kind,
   input  logic [7:0]               pid,
   input  logic [MAX_DATA_BITS-1:0] data,
   input  logic [LEN_W-1:0]         data_len,
   output logic                     ready_in,
   output logic                     bit_out,
   output logic                     bit_valid,
   input  logic                     bit_ready,
   output logic                     pkt_end,
   output logic                     busy
`ifdef USB_PID_CHECK_EN
   ,
   output logic                     pid_err
`endif
);

   ser_state_t               state;
   logic [LEN_W-1:0]         cnt;
   logic [LEN_W-1:0]         len_r;
   logic [LEN_W-1:0]         eff_len;
   logic [LEN_W-1:0]         crc_last;
   logic                     hsk_r;
   logic                     tok_r;
   logic [7:0]               pid_sr;
   logic [MAX_DATA_BITS-1:0] data_sr;
   logic                     xfer;
   logic                     pid_ok;
   logic                     accept;
   logic                     crc_shift;
   logic [4:0]               crc5;
   logic [15:0]              crc16;
   logic                     crc_unused;

   assign xfer      = bit_valid & bit_ready;
   assign ready_in  = (state == ST_IDLE);
   assign busy      = ~ready_in;
   assign bit_valid = ~ready_in;

`ifdef USB_PID_CHECK_EN
   assign pid_ok = (pid[7:4] == ~pid[3:0]);
`else
   assign pid_ok = 1'b1;
`endif

   assign accept   = ready_in & start & pid_ok;
   assign crc_last = tok_r ? LEN_W'(4) : LEN_W'(15);

   always_comb begin
      eff_len = '0;
      case (kind)
         PK_TOKEN: eff_len = LEN_W'(TOKEN_BITS);
         PK_DATA:  eff_len = (data_len > LEN_W'(MAX_DATA_BITS)) ? LEN_W'(MAX_DATA_BITS) : data_len;
         default:  eff_len = '0;
      endcase
   end

   // Control: packet phase sequencing, advanced only on transfers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         len_r <= '0;
         hsk_r <= 1'b0;
         tok_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  hsk_r <= is_hsk(kind);
                  tok_r <= (kind == PK_TOKEN);
                  len_r <= eff_len;
                  cnt   <= '0;
                  state <= ST_PID;
               end
            end
            ST_PID: begin
               if (xfer) begin
                  if (cnt == LEN_W'(PID_BITS - 1)) begin
                     cnt <= '0;
                     if (hsk_r)
                        state <= ST_IDLE;
                     else if (len_r == '0)
                        state <= ST_CRC;
                     else
                        state <= ST_DATA;
                  end else begin
                     cnt <= cnt + LEN_W'(1);
                  end
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  if (cnt + LEN_W'(1) == len_r) begin
                     cnt   <= '0;
                     state <= ST_CRC;
                  end else begin
                     cnt <= cnt + LEN_W'(1);
                  end
               end
            end
            ST_CRC: begin
               if (xfer) begin
                  if (cnt == crc_last) begin
                     cnt   <= '0;
                     state <= ST_IDLE;
                  end else begin
                     cnt <= cnt + LEN_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: PID and payload shift registers, serial bit always at index 0.
   always_ff @(posedge clk) begin
      if (accept) begin
         pid_sr  <= pid;
         data_sr <= data;
      end else if (xfer) begin
         if (state == ST_PID)
            pid_sr <= {1'b0, pid_sr[7:1]};
         if (state == ST_DATA)
            data_sr <= {1'b0, data_sr[MAX_DATA_BITS-1:1]};
      end
   end

   assign crc_shift = xfer & ((state == ST_DATA) | (state == ST_CRC));

   // Both LFSRs run in lockstep; the latched kind picks which one is emitted.
   usb_crc_lfsr #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
      .clk       (clk),
      .rst       (rst),
      .init      (accept),
      .shift_en  (crc_shift),
      .bit_in    (data_sr[0]),
      .send_mode (state == ST_CRC),
      .crc       (crc5)
   );

   usb_crc_lfsr #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
      .clk       (clk),
      .rst       (rst),
      .init      (accept),
      .shift_en  (crc_shift),
      .bit_in    (data_sr[0]),
      .send_mode (state == ST_CRC),
      .crc       (crc16)
   );

   assign crc_unused = ^{crc5[3:0], crc16[14:0]};

   always_comb begin
      bit_out = 1'b0;
      pkt_end = 1'b0;
      case (state)
         ST_PID: begin
            bit_out = pid_sr[0];
            pkt_end = hsk_r & (cnt == LEN_W'(PID_BITS - 1));
         end
         ST_DATA: bit_out = data_sr[0];
         ST_CRC: begin
            bit_out = tok_r ? ~crc5[4] : ~crc16[15];
            pkt_end = (cnt == crc_last);
         end
         default: begin
            bit_out = 1'b0;
            pkt_end = 1'b0;
         end
      endcase
   end

`ifdef USB_PID_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pid_err <= 1'b0;
      else
         pid_err <= ready_in & start & ~pid_ok;
   end
`endif

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Directed/randomized bench for usb_crc_serializer against a bit-queue reference model.
module tb_usb_crc_serializer;
   import usb_crc_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   pkt_kind_t   kind;
   logic [7:0]  pid;
   logic [63:0] data;
   logic [6:0]  data_len;
   logic        ready_in;
   logic        bit_out;
   logic        bit_valid;
   logic        bit_ready;
   logic        pkt_end;
   logic        busy;
`ifdef USB_PID_CHECK_EN
   logic        pid_err;
`endif

   int errors = 0;
   int checks = 0;
   logic [127:0] last_gv;
   int           last_gn;

   usb_crc_serializer #(.MAX_DATA_BITS(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .kind      (kind),
      .pid       (pid),
      .data      (data),
      .data_len  (data_len),
      .ready_in  (ready_in),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .pkt_end   (pkt_end),
      .busy      (busy)
`ifdef USB_PID_CHECK_EN
      ,
      .pid_err   (pid_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Receiver-style CRC register run over n bits of v starting at index from.
   function automatic int lfsr_run(input logic [127:0] v, input int from, input int n, input int w);
      int poly, mask, r, fb;
      poly = (w == 5) ? 'h05 : 'h8005;
      mask = (1 << w) - 1;
      r    = mask;
      for (int i = 0; i < n; i++) begin
         fb = ((r >> (w - 1)) & 1) ^ int'(v[from + i]);
         r  = ((r << 1) & mask) ^ ((fb != 0) ? poly : 0);
      end
      return r;
   endfunction

   // Expected serial packet: PID LSB first, payload LSB first, inverted CRC MSB first.
   function automatic void model(input int k, input logic [7:0] p, input logic [63:0] d,
                                 input int dl, output logic [127:0] v, output int n);
      int len, w, crc;
      v = '0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         v[n] = p[i];
         n++;
      end
      if (k == 0 || k == 3) return;
      if (k == 1) begin
         len = 11;
         w   = 5;
      end else begin
         len = (dl > 64) ? 64 : dl;
         w   = 16;
      end
      for (int i = 0; i < len; i++) begin
         v[n] = d[i];
         n++;
      end
      crc = lfsr_run(v, 8, len, w);
      for (int i = 0; i < w; i++) begin
         v[n] = ~crc[w - 1 - i];
         n++;
      end
   endfunction

   // Called at a negedge with the block idle; returns at the negedge after pkt_end transfers.
   task automatic send(input int k, input logic [7:0] p, input logic [63:0] d, input int dl,
                       input int stall, input bit busy_start, input bit chk_res, input string tag);
      logic [127:0] ev, gv;
      int           en, gn, cyc, stall_err, w, res;
      bit           done, held;
      logic         hb, he;
      logic [1:0]   kb;
      model(k, p, d, dl, ev, en);
      kb       = k[1:0];
      start    = 1'b1;
      kind     = pkt_kind_t'(kb);
      pid      = p;
      data     = d;
      data_len = 7'(dl);
      @(negedge clk);
      start    = 1'b0;
      pid      = 8'($urandom);
      data     = {$urandom, $urandom};
      data_len = 7'($urandom);
      chk({tag, "_first_valid"}, bit_valid, 1'b1);
      gv = '0; gn = 0; cyc = 0; stall_err = 0; done = 0; held = 0; hb = 0; he = 0;
      while (!done && cyc < 500) begin
         if (held && (bit_valid !== 1'b1 || bit_out !== hb || pkt_end !== he)) stall_err++;
         bit_ready = ($urandom_range(99) >= stall);
         start     = busy_start;
         if (bit_valid && bit_ready) begin
            if (gn < 128) gv[gn] = bit_out;
            gn++;
            if (pkt_end) done = 1;
            held = 0;
         end else begin
            held = bit_valid;
            hb   = bit_out;
            he   = pkt_end;
         end
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      bit_ready = 1'b1;
      chk({tag, "_pkt_end_seen"}, done, 1'b1);
      chk({tag, "_bit_count"}, gn, en);
      chk({tag, "_bits"}, gv, ev);
      chk({tag, "_stall_hold"}, stall_err, 0);
      chk({tag, "_ready_after"}, {ready_in, busy, bit_valid}, 3'b100);
      if (chk_res) begin
         w   = (k == 1) ? 5 : 16;
         res = lfsr_run(gv, 8, gn - 8, w);
         chk({tag, "_residual"}, res, (w == 5) ? 'h0C : 'h800D);
      end
      last_gv = gv;
      last_gn = gn;
   endtask

   initial begin
      logic [3:0]  nib;
      logic [63:0] rd;
      int          ends;
      rst       = 1'b1;
      start     = 1'b0;
      kind      = PK_HSK;
      pid       = 8'h00;
      data      = '0;
      data_len  = '0;
      bit_ready = 1'b1;
      #12;
      chk("rst_ready_in", ready_in, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_bit_valid", bit_valid, 1'b0);
      chk("rst_bit_out", bit_out, 1'b0);
      chk("rst_pkt_end", pkt_end, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send(0, 8'hD2, 64'h0, 0, 0, 0, 0, "hsk");
      chk("hsk_literal", last_gv[7:0], 8'hD2);

      send(1, 8'hE1, 64'h0, 0, 0, 0, 0, "tok0");
      chk("tok0_crc_literal", last_gv[23:19], 5'b00010);
      chk("tok0_len_literal", last_gn, 24);

      send(2, 8'hC3, 64'h0, 0, 0, 0, 0, "data0");
      chk("data0_crc_zero", last_gv[23:8], 16'h0);

      rd = {$urandom, $urandom};
      send(2, 8'hC3, rd, 32, 50, 0, 1, "data32");

      nib = 4'($urandom_range(15));
      rd  = {$urandom, $urandom};
      send(1, {~nib, nib}, rd, 0, 50, 0, 1, "tokr");

      // back-to-back with the 1-cycle gap, then reserved kind and oversize length
      send(3, 8'h5A, {$urandom, $urandom}, 40, 30, 0, 0, "rsvd");
      rd = {$urandom, $urandom};
      send(2, 8'h4B, rd, 100, 30, 0, 1, "clamp");
      send(2, 8'hC3, {$urandom, $urandom}, 17, 20, 1, 1, "busy_start");
      repeat (3) @(negedge clk);
      chk("busy_start_no_queue", bit_valid, 1'b0);

      // abort mid-DATA
      start    = 1'b1;
      kind     = PK_DATA;
      pid      = 8'hC3;
      data     = {$urandom, $urandom};
      data_len = 7'd32;
      @(negedge clk);
      start = 1'b0;
      ends  = 0;
      repeat (20) begin
         if (pkt_end) ends++;
         @(negedge clk);
      end
      chk("abort_no_end_before", ends, 0);
      #2 rst = 1'b1;
      #1;
      chk("abort_outputs", {bit_valid, pkt_end, bit_out, ready_in, busy}, 5'b00010);
      @(negedge clk);
      rst = 1'b0;
      nib = 4'($urandom_range(15));
      send(1, {~nib, nib}, {$urandom, $urandom}, 0, 0, 0, 1, "post_abort");

`ifdef USB_PID_CHECK_EN
      start = 1'b1;
      kind  = PK_TOKEN;
      pid   = 8'hE2;
      @(negedge clk);
      start = 1'b0;
      chk("piderr_pulse", pid_err, 1'b1);
      chk("piderr_no_valid", bit_valid, 1'b0);
      chk("piderr_ready", ready_in, 1'b1);
      @(negedge clk);
      chk("piderr_one_cycle", pid_err, 1'b0);
      chk("piderr_still_idle", bit_valid, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
